// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - phase encodings and pixel width shared by the game control blocks
package game_pkg;

    localparam int PIXEL_W = 12;

    localparam logic [3:0] ST_IDLE     = 4'b0000;
    localparam logic [3:0] ST_PLAYER   = 4'b0001;
    localparam logic [3:0] ST_GAMEOVER = 4'b0010;
    localparam logic [3:0] ST_RESOLVE  = 4'b0100;
    localparam logic [3:0] ST_ENEMY    = 4'b1000;

    typedef enum logic [3:0] {
        PH_IDLE     = ST_IDLE,
        PH_PLAYER   = ST_PLAYER,
        PH_GAMEOVER = ST_GAMEOVER,
        PH_RESOLVE  = ST_RESOLVE,
        PH_ENEMY    = ST_ENEMY
    } phase_e;

    function automatic logic is_busy(input phase_e ph);
        return (ph == PH_PLAYER) || (ph == PH_ENEMY) || (ph == PH_RESOLVE);
    endfunction

endpackage

// File: rtl/frame_sync.sv
// rtl/frame_sync.sv - one-cycle frame tick at the raster origin
module frame_sync (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_i,
    input  logic [9:0]  vcount_i,
    output logic        tick_o
);

    logic at_origin;
    logic at_origin_q;

    assign at_origin = (hcount_i == 11'd0) && (vcount_i == 10'd0);

    // Edge-qualified so a raster that dwells on the origin still counts one frame
    always_ff @(posedge clk) begin
        if (rst) begin
            at_origin_q <= 1'b0;
        end else begin
            at_origin_q <= at_origin;
        end
    end

    assign tick_o = at_origin && !at_origin_q;

endmodule

// File: rtl/game_phase_ctrl.sv
// rtl/game_phase_ctrl.sv - turn/round sequencer with frame timeout and phase-synchronous pixel mux
module game_phase_ctrl
    import game_pkg::*;
#(
    parameter int                 NUM_PLAYERS    = 2,
    parameter int                 MAX_ROUNDS     = 8,
    parameter int                 TIMEOUT_FRAMES = 600,
    parameter logic [PIXEL_W-1:0] BG_COLOR       = 12'h000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [10:0]        hcount_in,
    input  logic [9:0]         vcount_in,
    input  logic               start_in,
    input  logic               phase_done_in,
    input  logic               game_over_in,
    input  logic [PIXEL_W-1:0] player_pixel_in,
    input  logic [PIXEL_W-1:0] enemy_pixel_in,
    input  logic [PIXEL_W-1:0] resolve_pixel_in,
    output logic [3:0]         state_out,
    output logic [3:0]         turn_out,
    output logic [7:0]         round_out,
    output logic               phase_start_out,
    output logic               busy_out,
    output logic               timeout_out,
    output logic [PIXEL_W-1:0] pixel_out
);

    localparam int CNT_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

    phase_e             state_q, state_d;
    phase_e             disp_q;
    logic [3:0]         turn_q, turn_d;
    logic [7:0]         round_q, round_d;
    logic               armed_q, armed_d;
    logic               start_q;
    logic               timeout_q;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic [PIXEL_W-1:0] pixel_q, pixel_d;
    logic               enter;
    logic               frame_tick;
    logic               busy;
    logic               real_done;
    logic               to_evt;
    logic               advance;

    frame_sync u_frame_sync (
        .clk      (clk),
        .rst      (rst),
        .hcount_i (hcount_in),
        .vcount_i (vcount_in),
        .tick_o   (frame_tick)
    );

    assign busy      = is_busy(state_q);
    assign real_done = phase_done_in && busy && !start_q;
    assign to_evt    = (TIMEOUT_FRAMES != 0) && busy && !start_q && frame_tick &&
                       (frame_cnt_q == CNT_W'(TIMEOUT_FRAMES - 1));
    assign advance   = real_done || to_evt;

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        round_d = round_q;
        armed_d = armed_q;
        enter   = 1'b0;
        case (state_q)
            PH_IDLE: begin
                // start must be seen low once after leaving GAMEOVER before it can launch a game
                if (!start_in) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = PH_PLAYER;
                    turn_d  = 4'd0;
                    round_d = 8'd0;
                    enter   = 1'b1;
                end
            end
            PH_PLAYER: begin
                if (advance) begin
                    enter = 1'b1;
                    if (turn_q < 4'(NUM_PLAYERS - 1)) begin
                        turn_d = turn_q + 4'd1;
                    end else begin
                        turn_d  = 4'd0;
                        state_d = PH_ENEMY;
                    end
                end
            end
            PH_ENEMY: begin
                if (advance) begin
                    state_d = PH_RESOLVE;
                    enter   = 1'b1;
                end
            end
            PH_RESOLVE: begin
                if (advance) begin
                    if ((real_done && game_over_in) || (round_q == 8'(MAX_ROUNDS - 1))) begin
                        state_d = PH_GAMEOVER;
                    end else begin
                        round_d = round_q + 8'd1;
                        turn_d  = 4'd0;
                        state_d = PH_PLAYER;
                        enter   = 1'b1;
                    end
                end
            end
            PH_GAMEOVER: begin
                if (start_in) begin
                    state_d = PH_IDLE;
                    turn_d  = 4'd0;
                    round_d = 8'd0;
                    armed_d = 1'b0;
                end
            end
            default: state_d = PH_IDLE;
        endcase
    end

    always_comb begin
        pixel_d = BG_COLOR;
        case (disp_q)
            PH_PLAYER:  pixel_d = player_pixel_in;
            PH_ENEMY:   pixel_d = enemy_pixel_in;
            PH_RESOLVE: pixel_d = resolve_pixel_in;
            default:    pixel_d = BG_COLOR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PH_IDLE;
            turn_q      <= 4'd0;
            round_q     <= 8'd0;
            armed_q     <= 1'b1;
            start_q     <= 1'b0;
            timeout_q   <= 1'b0;
            frame_cnt_q <= '0;
            disp_q      <= PH_IDLE;
            pixel_q     <= BG_COLOR;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            round_q   <= round_d;
            armed_q   <= armed_d;
            start_q   <= enter;
            timeout_q <= to_evt && !real_done;
            if (start_q) begin
                frame_cnt_q <= '0;
            end else if (frame_tick) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (frame_tick) begin
                disp_q <= state_q;
            end
            pixel_q <= pixel_d;
        end
    end

    assign state_out       = state_q;
    assign turn_out        = turn_q;
    assign round_out       = round_q;
    assign phase_start_out = start_q;
    assign busy_out        = busy;
    assign timeout_out     = timeout_q;
    assign pixel_out       = pixel_q;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// tb/tb_game_phase_ctrl.sv - scoreboarded bench for game_phase_ctrl
module tb_game_phase_ctrl;

    localparam logic [11:0] BG = 12'h05A;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        start_in, phase_done_in, game_over_in;
    logic [11:0] player_pixel_in, enemy_pixel_in, resolve_pixel_in;
    logic [3:0]  state_out, turn_out;
    logic [7:0]  round_out;
    logic        phase_start_out, busy_out, timeout_out;
    logic [11:0] pixel_out;

    int          total = 0;
    int          bad = 0;
    logic [15:0] sb[$];
    logic [15:0] mon_exp;

    always #5 clk = ~clk;

    game_phase_ctrl #(
        .NUM_PLAYERS(2), .MAX_ROUNDS(2), .TIMEOUT_FRAMES(3), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .start_in(start_in), .phase_done_in(phase_done_in), .game_over_in(game_over_in),
        .player_pixel_in(player_pixel_in), .enemy_pixel_in(enemy_pixel_in),
        .resolve_pixel_in(resolve_pixel_in), .state_out(state_out), .turn_out(turn_out),
        .round_out(round_out), .phase_start_out(phase_start_out), .busy_out(busy_out),
        .timeout_out(timeout_out), .pixel_out(pixel_out)
    );

    // Every phase_start_out pulse must match the next expected {state, turn, round}
    always @(negedge clk) begin
        if (phase_start_out === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_start: got state=%b turn=%0d round=%0d, required no pulse",
                         state_out, turn_out, round_out);
            end else begin
                mon_exp = sb.pop_front();
                if ({state_out, turn_out, round_out} !== mon_exp) begin
                    bad++;
                    $display("FAIL sb_phase_start: got %h, required %h",
                             {state_out, turn_out, round_out}, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        phase_done_in = 1'b1;
        cyc();
        phase_done_in = 1'b0;
        cyc();
    endtask

    task automatic frame_tick();
        hcount_in = 11'd0; vcount_in = 10'd0;
        cyc();
        hcount_in = 11'd5; vcount_in = 10'd5;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        total += 7;
        if (state_out !== 4'b0000) begin bad++; $display("FAIL rst_state: got %b, required 0000", state_out); end
        if (turn_out !== 4'd0) begin bad++; $display("FAIL rst_turn: got %0d, required 0", turn_out); end
        if (round_out !== 8'd0) begin bad++; $display("FAIL rst_round: got %0d, required 0", round_out); end
        if (phase_start_out !== 1'b0) begin bad++; $display("FAIL rst_pstart: got %b, required 0", phase_start_out); end
        if (busy_out !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b, required 0", busy_out); end
        if (timeout_out !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b, required 0", timeout_out); end
        if (pixel_out !== BG) begin bad++; $display("FAIL rst_pixel: got %h, required %h", pixel_out, BG); end
    endtask

    task automatic test_start();
        sb.push_back({4'b0001, 4'd0, 8'd0});
        start_in = 1'b1;
        cyc();
        start_in = 1'b0;
        total += 4;
        if (state_out !== 4'b0001) begin bad++; $display("FAIL start_state: got %b, required 0001", state_out); end
        if (turn_out !== 4'd0) begin bad++; $display("FAIL start_turn: got %0d, required 0", turn_out); end
        if (phase_start_out !== 1'b1) begin bad++; $display("FAIL start_pulse: got %b, required 1", phase_start_out); end
        if (busy_out !== 1'b1) begin bad++; $display("FAIL start_busy: got %b, required 1", busy_out); end
        phase_done_in = 1'b1;
        cyc();
        phase_done_in = 1'b0;
        total++;
        if (turn_out !== 4'd0) begin bad++; $display("FAIL done_in_pulse_ignored: got turn %0d, required 0", turn_out); end
        sb.push_back({4'b0001, 4'd1, 8'd0});
        phase_done_in = 1'b1;
        cyc();
        phase_done_in = 1'b0;
        total += 2;
        if (turn_out !== 4'd1) begin bad++; $display("FAIL turn_incr: got %0d, required 1", turn_out); end
        if (phase_start_out !== 1'b1) begin bad++; $display("FAIL turn_pulse: got %b, required 1", phase_start_out); end
        cyc();
    endtask

    task automatic test_full_run();
        sb.push_back({4'b1000, 4'd0, 8'd0}); pulse_done();
        total++;
        if (state_out !== 4'b1000) begin bad++; $display("FAIL run_enemy: got %b, required 1000", state_out); end
        sb.push_back({4'b0100, 4'd0, 8'd0}); pulse_done();
        sb.push_back({4'b0001, 4'd0, 8'd1}); pulse_done();
        total++;
        if (round_out !== 8'd1) begin bad++; $display("FAIL run_round1: got %0d, required 1", round_out); end
        sb.push_back({4'b0001, 4'd1, 8'd1}); pulse_done();
        sb.push_back({4'b1000, 4'd0, 8'd1}); pulse_done();
        sb.push_back({4'b0100, 4'd0, 8'd1}); pulse_done();
        pulse_done();
        total += 3;
        if (state_out !== 4'b0010) begin bad++; $display("FAIL run_gameover: got %b, required 0010", state_out); end
        if (busy_out !== 1'b0) begin bad++; $display("FAIL run_busy: got %b, required 0", busy_out); end
        if (round_out !== 8'd1) begin bad++; $display("FAIL run_final_round: got %0d, required 1", round_out); end
        pulse_done();
        total++;
        if (state_out !== 4'b0010) begin bad++; $display("FAIL gameover_done_ignored: got %b, required 0010", state_out); end
        start_in = 1'b1;
        cyc();
        total += 2;
        if (state_out !== 4'b0000) begin bad++; $display("FAIL back_to_idle: got %b, required 0000", state_out); end
        if (round_out !== 8'd0) begin bad++; $display("FAIL idle_round_clr: got %0d, required 0", round_out); end
        cyc();
        total++;
        if (state_out !== 4'b0000) begin bad++; $display("FAIL idle_held_start: got %b, required 0000", state_out); end
        start_in = 1'b0;
        cyc();
        sb.push_back({4'b0001, 4'd0, 8'd0});
        start_in = 1'b1;
        cyc();
        start_in = 1'b0;
        total++;
        if (state_out !== 4'b0001) begin bad++; $display("FAIL restart: got %b, required 0001", state_out); end
        cyc();
    endtask

    task automatic test_game_over();
        sb.push_back({4'b0001, 4'd1, 8'd0}); pulse_done();
        sb.push_back({4'b1000, 4'd0, 8'd0}); pulse_done();
        sb.push_back({4'b0100, 4'd0, 8'd0}); pulse_done();
        game_over_in = 1'b1;
        pulse_done();
        game_over_in = 1'b0;
        total += 2;
        if (state_out !== 4'b0010) begin bad++; $display("FAIL early_over_state: got %b, required 0010", state_out); end
        if (round_out !== 8'd0) begin bad++; $display("FAIL early_over_round: got %0d, required 0", round_out); end
        start_in = 1'b1; cyc();
        start_in = 1'b0; cyc();
    endtask

    task automatic test_timeout();
        sb.push_back({4'b0001, 4'd0, 8'd0});
        start_in = 1'b1; cyc();
        start_in = 1'b0; cyc();
        sb.push_back({4'b0001, 4'd1, 8'd0}); pulse_done();
        sb.push_back({4'b1000, 4'd0, 8'd0}); pulse_done();
        frame_tick(); frame_tick();
        total += 2;
        if (state_out !== 4'b1000) begin bad++; $display("FAIL to_early_state: got %b, required 1000", state_out); end
        if (timeout_out !== 1'b0) begin bad++; $display("FAIL to_early_pulse: got %b, required 0", timeout_out); end
        sb.push_back({4'b0100, 4'd0, 8'd0});
        hcount_in = 11'd0; vcount_in = 10'd0;
        cyc();
        hcount_in = 11'd5; vcount_in = 10'd5;
        total += 2;
        if (state_out !== 4'b0100) begin bad++; $display("FAIL to_state: got %b, required 0100", state_out); end
        if (timeout_out !== 1'b1) begin bad++; $display("FAIL to_pulse: got %b, required 1", timeout_out); end
        cyc();
        total++;
        if (timeout_out !== 1'b0) begin bad++; $display("FAIL to_single: got %b, required 0", timeout_out); end
        frame_tick(); frame_tick();
        sb.push_back({4'b0001, 4'd0, 8'd1});
        hcount_in = 11'd0; vcount_in = 10'd0; phase_done_in = 1'b1;
        cyc();
        hcount_in = 11'd5; vcount_in = 10'd5; phase_done_in = 1'b0;
        total += 3;
        if (state_out !== 4'b0001) begin bad++; $display("FAIL simul_state: got %b, required 0001", state_out); end
        if (round_out !== 8'd1) begin bad++; $display("FAIL simul_round: got %0d, required 1", round_out); end
        if (timeout_out !== 1'b0) begin bad++; $display("FAIL simul_no_to: got %b, required 0", timeout_out); end
        cyc();
        total += 2;
        if (turn_out !== 4'd0) begin bad++; $display("FAIL simul_once: got turn %0d, required 0", turn_out); end
        if (timeout_out !== 1'b0) begin bad++; $display("FAIL simul_no_to2: got %b, required 0", timeout_out); end
    endtask

    task automatic test_reset_mid();
        sb.push_back({4'b0001, 4'd1, 8'd1}); pulse_done();
        sb.push_back({4'b1000, 4'd0, 8'd1}); pulse_done();
        sb.push_back({4'b0100, 4'd0, 8'd1}); pulse_done();
        total++;
        if ({state_out, round_out} !== {4'b0100, 8'd1}) begin
            bad++; $display("FAIL mid_pre: got %b/%0d, required 0100/1", state_out, round_out);
        end
        rst = 1'b1; cyc(); rst = 1'b0;
        total += 6;
        if (state_out !== 4'b0000) begin bad++; $display("FAIL mid_rst_state: got %b, required 0000", state_out); end
        if (round_out !== 8'd0) begin bad++; $display("FAIL mid_rst_round: got %0d, required 0", round_out); end
        if (phase_start_out !== 1'b0) begin bad++; $display("FAIL mid_rst_pstart: got %b, required 0", phase_start_out); end
        if (busy_out !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b, required 0", busy_out); end
        if (timeout_out !== 1'b0) begin bad++; $display("FAIL mid_rst_to: got %b, required 0", timeout_out); end
        if (pixel_out !== BG) begin bad++; $display("FAIL mid_rst_pixel: got %h, required %h", pixel_out, BG); end
        pulse_done(); pulse_done();
        total++;
        if (state_out !== 4'b0000) begin bad++; $display("FAIL mid_done_ignored: got %b, required 0000", state_out); end
    endtask

    task automatic test_pixel();
        player_pixel_in = 12'h0F0; enemy_pixel_in = 12'hF00; resolve_pixel_in = 12'h00F;
        sb.push_back({4'b0001, 4'd0, 8'd0});
        start_in = 1'b1; cyc();
        start_in = 1'b0; cyc();
        sb.push_back({4'b0001, 4'd1, 8'd0}); pulse_done();
        sb.push_back({4'b1000, 4'd0, 8'd0}); pulse_done();
        total++;
        if (pixel_out !== BG) begin bad++; $display("FAIL pix_no_tick: got %h, required %h", pixel_out, BG); end
        hcount_in = 11'd0; vcount_in = 10'd0;
        cyc();
        hcount_in = 11'd5; vcount_in = 10'd5;
        total++;
        if (pixel_out !== BG) begin bad++; $display("FAIL pix_tick_cycle: got %h, required %h", pixel_out, BG); end
        cyc();
        total++;
        if (pixel_out !== 12'hF00) begin bad++; $display("FAIL pix_enemy: got %h, required f00", pixel_out); end
        enemy_pixel_in = 12'h123;
        cyc();
        total++;
        if (pixel_out !== 12'h123) begin bad++; $display("FAIL pix_latency: got %h, required 123", pixel_out); end
        sb.push_back({4'b0100, 4'd0, 8'd0}); pulse_done();
        total++;
        if (pixel_out !== 12'h123) begin bad++; $display("FAIL pix_mid_frame: got %h, required 123", pixel_out); end
        frame_tick();
        total++;
        if (pixel_out !== 12'h00F) begin bad++; $display("FAIL pix_resolve: got %h, required 00f", pixel_out); end
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b0; phase_done_in = 1'b0; game_over_in = 1'b0;
        hcount_in = 11'd5; vcount_in = 10'd5;
        player_pixel_in = 12'h111; enemy_pixel_in = 12'h222; resolve_pixel_in = 12'h333;
        test_reset();
        test_start();
        test_full_run();
        test_game_over();
        test_timeout();
        test_reset_mid();
        test_pixel();
        cyc(); cyc();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_phase_ctrl.md
GAME_PHASE_CTRL -- requirements
Module: game_phase_ctrl

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of player turns per round (1..15).
REQ-002 Parameter MAX_ROUNDS, default 8, rounds before forced game over (1..255).
REQ-003 Parameter TIMEOUT_FRAMES, default 600, frames a phase may last before forced advance; 0 disables timeout.
REQ-004 Parameter BG_COLOR, default 12'h000, pixel shown in IDLE and GAMEOVER.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 hcount_in  input  11  current pixel column.
REQ-008 vcount_in  input  10  current pixel row.
REQ-009 start_in  input  1  level; starts game from IDLE, returns to IDLE from GAMEOVER.
REQ-010 phase_done_in  input  1  one-cycle pulse from active sub-block: phase finished.
REQ-011 game_over_in  input  1  level, sampled only with phase_done_in in RESOLVE.
REQ-012 player_pixel_in, enemy_pixel_in, resolve_pixel_in  input  12 each  sub-block pixels.
REQ-013 state_out  output  4  current phase: IDLE 4'b0000, PLAYER 4'b0001, GAMEOVER 4'b0010, RESOLVE 4'b0100, ENEMY 4'b1000.
REQ-014 turn_out  output  4  active player index in PLAYER, else 0.
REQ-015 round_out  output  8  current round index, 0-based.
REQ-016 phase_start_out  output  1  one-cycle pulse: active sub-block begins.
REQ-017 busy_out  output  1  high in PLAYER, ENEMY, RESOLVE.
REQ-018 timeout_out  output  1  one-cycle pulse when a phase is force-advanced.
REQ-019 pixel_out  output  12  composited pixel.

Function
REQ-020 IDLE: start_in=1 -> PLAYER, turn 0, round 0.
REQ-021 PLAYER: done with turn_out<NUM_PLAYERS-1 -> stay PLAYER, turn_out+1; done on last turn -> ENEMY, turn_out=0.
REQ-022 ENEMY: done -> RESOLVE.
REQ-023 RESOLVE: done with game_over_in=1 or round_out=MAX_ROUNDS-1 -> GAMEOVER; otherwise round_out+1, -> PLAYER turn 0.
REQ-024 GAMEOVER: start_in=1 -> IDLE, turn_out and round_out cleared; start_in must drop and re-assert to leave IDLE again (edge-qualified in GAMEOVER->IDLE->PLAYER path: IDLE requires start_in low for at least one cycle after entry).
REQ-025 Transitions take effect on the clock edge sampling the event; state_out, turn_out, round_out registered.
REQ-026 phase_start_out pulses exactly one cycle, in the cycle after any entry to PLAYER/ENEMY/RESOLVE or turn increment.
REQ-027 phase_done_in is ignored in IDLE, GAMEOVER, and in any cycle phase_start_out is high.
REQ-028 Frame tick = cycle with hcount_in==0 and vcount_in==0; frame counter clears on every phase_start_out, increments per tick.
REQ-029 Frame counter reaching TIMEOUT_FRAMES acts as phase_done_in (game_over_in treated as 0) and pulses timeout_out the same cycle; simultaneous real done counts once, timeout_out not pulsed.
REQ-030 Display phase register latches state_out only on frame tick; pixel mux selects by display phase, not live state.
REQ-031 pixel_out registered, 1-cycle latency from pixel inputs: PLAYER->player_pixel_in, ENEMY->enemy_pixel_in, RESOLVE->resolve_pixel_in, IDLE/GAMEOVER->BG_COLOR.

Reset
REQ-032 rst=1 on clock edge: state IDLE, turn_out 0, round_out 0, phase_start_out 0, busy_out 0, timeout_out 0, frame counter 0, display phase IDLE, pixel_out BG_COLOR.
REQ-033 Reset mid-phase aborts with no phase_start_out or timeout_out pulse in or after the reset cycle until a new start.

Structure
REQ-034 Package game_pkg holds the 4-bit phase enum typedef, its encodings, and pixel width constant 12; enemy and other sub-blocks import it.
REQ-035 One sub-module frame_sync generates the frame tick pulse from hcount_in/vcount_in.

Verification (NUM_PLAYERS=2, MAX_ROUNDS=2, TIMEOUT_FRAMES=3)
REQ-036 start_in=1 from IDLE -> state_out 4'b0001, turn_out 0, phase_start_out pulse next cycle; done -> turn_out 1 with new pulse.
REQ-037 Full run of dones -> PLAYER t0, PLAYER t1, ENEMY, RESOLVE, PLAYER round 1, ..., RESOLVE done -> GAMEOVER 4'b0010, busy_out 0.
REQ-038 RESOLVE done with game_over_in=1 in round 0 -> GAMEOVER, round_out stays 0.
REQ-039 No done in ENEMY for 3 frame ticks -> RESOLVE, timeout_out single pulse; done on the same tick -> single transition, no timeout_out.
REQ-040 State changes mid-frame -> pixel_out source switches only after next hcount=0,vcount=0, one cycle later; enemy_pixel_in=12'hF00 appears as pixel_out=12'hF00.
REQ-041 rst asserted in RESOLVE round 1 -> all outputs per REQ-032 next cycle; done pulses then ignored until start_in.
